// File: rtl/cache_mem_arbiter_if.sv
// Bus bundle between the I-cache/D-cache fill logic and the memory arbiter.
// master: the cache side (drives requests, observes grants and memory bus).
// slave:  the arbiter (observes requests, drives grants and memory bus).
// dbg_state exposes the arbiter FSM state for observation.
interface cache_mem_arbiter_if;
    logic        icache_req;
    logic [15:0] icache_addr;
    logic        icache_done;
    logic        dcache_req;
    logic        dcache_wr;
    logic [15:0] dcache_addr;
    logic [15:0] dcache_wdata;
    logic        dcache_done;
    logic        icache_grant;
    logic        dcache_grant;
    logic        mem_enable;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        arb_busy;
    logic        arb_error;
    logic [1:0]  dbg_state;

    modport master (
        output icache_req, icache_addr, icache_done,
        output dcache_req, dcache_wr, dcache_addr, dcache_wdata, dcache_done,
        input  icache_grant, dcache_grant, mem_enable, mem_wr,
        input  mem_addr, mem_wdata, arb_busy, arb_error, dbg_state
    );

    modport slave (
        input  icache_req, icache_addr, icache_done,
        input  dcache_req, dcache_wr, dcache_addr, dcache_wdata, dcache_done,
        output icache_grant, dcache_grant, mem_enable, mem_wr,
        output mem_addr, mem_wdata, arb_busy, arb_error, dbg_state
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Memory arbiter between an I-cache fill engine and a D-cache (fill or
// single-cycle write-through store).
// Handshake: a request is sampled only while the arbiter is IDLE; the grant
// appears the cycle after. A fill grant (I or D) is held until the owner's
// done pulse or a 63-cycle watchdog timeout; a D write grant lasts exactly
// one cycle. Requests and done pulses are ignored outside those windows.
// Every grant is followed by at least one IDLE cycle.
// Optional macro ARB_ROUND_ROBIN_EN: when defined, a simultaneous I/D
// request is given to the requester that did not own memory last; when
// undefined, the D-cache always wins a tie.
module cache_mem_arbiter (
    input  logic                clk,
    input  logic                rst,
    cache_mem_arbiter_if.slave  bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GNT_I  = 2'd1;
    localparam logic [1:0] ST_GNT_DF = 2'd2;
    localparam logic [1:0] ST_GNT_DW = 2'd3;

    // Value the watchdog reaches on the last cycle a fill may stay granted.
    localparam logic [5:0] WD_LIMIT  = 6'd63;

    logic [1:0] state_q, state_d;
    logic [5:0] wd_q, wd_d;
    logic       err_q, err_d;
    logic       pick_d;
    logic       pick_i;
    logic       owner_done;
    logic       wd_expire;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = D-cache owned memory last, 0 = I-cache owned it last.
    logic       last_d_q, last_d_d;

    // Tie-break: a tie goes to whoever did not own last.
    always_comb begin
        pick_d = bus.dcache_req & ~(bus.icache_req & last_d_q);
        pick_i = bus.icache_req & ~pick_d;
    end
`else
    // Tie-break: the D-cache always wins.
    always_comb begin
        pick_d = bus.dcache_req;
        pick_i = bus.icache_req & ~bus.dcache_req;
    end
`endif

    // Done pulse of the current fill owner, and watchdog expiry this cycle.
    always_comb begin
        owner_done = 1'b0;
        if (state_q == ST_GNT_I)  owner_done = bus.icache_done;
        if (state_q == ST_GNT_DF) owner_done = bus.dcache_done;
        wd_expire = ((wd_q + 6'd1) == WD_LIMIT);
    end

    // Next-state, watchdog and sticky error logic.
    always_comb begin
        state_d  = state_q;
        wd_d     = wd_q;
        err_d    = err_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_d_d = last_d_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_d) begin
                    state_d  = bus.dcache_wr ? ST_GNT_DW : ST_GNT_DF;
                    wd_d     = 6'd0;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d_d = 1'b1;
`endif
                end else if (pick_i) begin
                    state_d  = ST_GNT_I;
                    wd_d     = 6'd0;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d_d = 1'b0;
`endif
                end
            end
            ST_GNT_I, ST_GNT_DF: begin
                wd_d = wd_q + 6'd1;
                if (owner_done) begin
                    // A done coinciding with expiry is a normal completion.
                    state_d = ST_IDLE;
                end else if (wd_expire) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end
            end
            ST_GNT_DW: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            wd_q     <= 6'd0;
            err_q    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d_q <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            wd_q     <= wd_d;
            err_q    <= err_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_d_q <= last_d_d;
`endif
        end
    end

    // Grant decode and combinational memory bus steering from the owner.
    always_comb begin
        bus.icache_grant = (state_q == ST_GNT_I);
        bus.dcache_grant = (state_q == ST_GNT_DF) || (state_q == ST_GNT_DW);
        bus.arb_busy     = (state_q != ST_IDLE);
        bus.mem_enable   = (state_q != ST_IDLE);
        bus.mem_wr       = (state_q == ST_GNT_DW);
        bus.mem_addr     = 16'd0;
        bus.mem_wdata    = 16'd0;
        if (state_q == ST_GNT_I) begin
            bus.mem_addr = bus.icache_addr;
        end else if (state_q != ST_IDLE) begin
            bus.mem_addr = bus.dcache_addr;
        end
        if (state_q == ST_GNT_DW) begin
            bus.mem_wdata = bus.dcache_wdata;
        end
        bus.arb_error    = err_q;
        bus.dbg_state    = state_q;
    end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter. The driver applies inputs for a cycle
// and pushes the expected output vector tagged with that cycle; a monitor on
// the falling edge pops and compares. Honours ARB_ROUND_ROBIN_EN if defined.
module tb_cache_mem_arbiter;
    localparam int W = 38;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic [W-1:0] exp_q[$];
    int           exp_cyc_q[$];
    string        exp_nm_q[$];

    cache_mem_arbiter_if bus();

    cache_mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation tagged for the current cycle.
    always @(negedge clk) begin
        logic [W-1:0] act;
        logic [W-1:0] ev;
        int           ec;
        string        nm;
        act = {bus.icache_grant, bus.dcache_grant, bus.mem_enable, bus.mem_wr,
               bus.mem_addr, bus.mem_wdata, bus.arb_busy, bus.arb_error};
        while (exp_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
            ev = exp_q.pop_front();
            ec = exp_cyc_q.pop_front();
            nm = exp_nm_q.pop_front();
            checks++;
            if (ec != cyc) begin
                errors++;
                $display("FAIL %s: expectation for cycle %0d seen at cycle %0d", nm, ec, cyc);
            end else if (act !== ev) begin
                errors++;
                $display("FAIL %s: cycle %0d got ig=%b dg=%b en=%b wr=%b addr=%h wdata=%h busy=%b err=%b, expected ig=%b dg=%b en=%b wr=%b addr=%h wdata=%h busy=%b err=%b",
                         nm, cyc, act[37], act[36], act[35], act[34], act[33:18], act[17:2], act[1], act[0],
                         ev[37], ev[36], ev[35], ev[34], ev[33:18], ev[17:2], ev[1], ev[0]);
            end
        end
    end

    // Driver helpers.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_out(input string nm, input logic ig, input logic dg, input logic wr,
                           input logic [15:0] a, input logic [15:0] wd, input logic err);
        logic busy;
        busy = ig | dg;
        exp_q.push_back({ig, dg, busy, wr, a, wd, busy, err});
        exp_cyc_q.push_back(cyc);
        exp_nm_q.push_back(nm);
    endtask

    task automatic exp_idle(input string nm, input logic err);
        exp_out(nm, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, err);
    endtask

    task automatic exp_i(input string nm, input logic [15:0] a, input logic err);
        exp_out(nm, 1'b1, 1'b0, 1'b0, a, 16'h0000, err);
    endtask

    task automatic exp_df(input string nm, input logic [15:0] a);
        exp_out(nm, 1'b0, 1'b1, 1'b0, a, 16'h0000, 1'b0);
    endtask

    // Directed stimulus.
    initial begin
        bus.icache_req   = 1'b0;
        bus.icache_addr  = 16'h0000;
        bus.icache_done  = 1'b0;
        bus.dcache_req   = 1'b0;
        bus.dcache_wr    = 1'b0;
        bus.dcache_addr  = 16'h0000;
        bus.dcache_wdata = 16'h0000;
        bus.dcache_done  = 1'b0;

        // Reset.
        rst = 1'b1;
        tick();
        exp_idle("reset", 1'b0);
        tick();
        rst = 1'b0;
        exp_idle("reset_release", 1'b0);
        tick();

        // Simple I-cache fill.
        bus.icache_req = 1'b1; bus.icache_addr = 16'h0040;
        exp_idle("i_req_latency", 1'b0);
        tick();
        exp_i("i_grant", 16'h0040, 1'b0);
        tick();
        bus.icache_req = 1'b0; bus.icache_done = 1'b1;
        exp_i("i_grant_done_cycle", 16'h0040, 1'b0);
        tick();
        bus.icache_done = 1'b0;
        exp_idle("i_after_done", 1'b0);
        tick();

        // Foreign done pulse during GNT_I, request dropped mid-grant.
        bus.icache_req = 1'b1; bus.icache_addr = 16'h0080;
        exp_idle("fd_req", 1'b0);
        tick();
        bus.icache_req = 1'b0; bus.dcache_done = 1'b1;
        exp_i("fd_dcache_done_ignored", 16'h0080, 1'b0);
        tick();
        bus.dcache_done = 1'b0;
        exp_i("fd_grant_held", 16'h0080, 1'b0);
        tick();
        bus.icache_done = 1'b1;
        exp_i("fd_done_cycle", 16'h0080, 1'b0);
        tick();
        bus.icache_done = 1'b0;
        exp_idle("fd_idle", 1'b0);
        tick();

        // Simultaneous requests; last owner was I so D wins in both modes.
        bus.icache_req = 1'b1; bus.icache_addr = 16'h0100;
        bus.dcache_req = 1'b1; bus.dcache_wr = 1'b0; bus.dcache_addr = 16'h2000;
        exp_idle("tie_req", 1'b0);
        tick();
        exp_df("tie_d_wins", 16'h2000);
        tick();
        bus.dcache_done = 1'b1;
        exp_df("tie_d_done_cycle", 16'h2000);
        tick();
        bus.dcache_done = 1'b0;
        exp_idle("tie_bubble", 1'b0);
        tick();
`ifdef ARB_ROUND_ROBIN_EN
        // Second tie: D owned last, so I goes first.
        exp_i("tie2_i_first", 16'h0100, 1'b0);
        tick();
        bus.icache_req = 1'b0; bus.icache_done = 1'b1;
        exp_i("tie2_i_done_cycle", 16'h0100, 1'b0);
        tick();
        bus.icache_done = 1'b0;
        exp_idle("tie2_bubble", 1'b0);
        tick();
        exp_df("tie2_d_second", 16'h2000);
        tick();
        bus.dcache_req = 1'b0; bus.dcache_done = 1'b1;
        exp_df("tie2_d_done_cycle", 16'h2000);
        tick();
        bus.dcache_done = 1'b0;
        exp_idle("tie2_idle", 1'b0);
        tick();
`else
        // Second tie: fixed priority, D again.
        exp_df("tie2_d_again", 16'h2000);
        tick();
        bus.dcache_req = 1'b0; bus.dcache_done = 1'b1;
        exp_df("tie2_d_done_cycle", 16'h2000);
        tick();
        bus.dcache_done = 1'b0;
        exp_idle("tie2_bubble", 1'b0);
        tick();
        exp_i("tie2_i_second", 16'h0100, 1'b0);
        tick();
        bus.icache_req = 1'b0; bus.icache_done = 1'b1;
        exp_i("tie2_i_done_cycle", 16'h0100, 1'b0);
        tick();
        bus.icache_done = 1'b0;
        exp_idle("tie2_idle", 1'b0);
        tick();
`endif

        // Write-through store: exactly one cycle, done ignored.
        bus.dcache_req = 1'b1; bus.dcache_wr = 1'b1;
        bus.dcache_addr = 16'h1234; bus.dcache_wdata = 16'hBEEF;
        exp_idle("dw_req", 1'b0);
        tick();
        bus.dcache_req = 1'b0; bus.dcache_done = 1'b1;
        exp_out("dw_write", 1'b0, 1'b1, 1'b1, 16'h1234, 16'hBEEF, 1'b0);
        tick();
        bus.dcache_done = 1'b0;
        exp_idle("dw_one_cycle", 1'b0);
        tick();
        bus.dcache_wr = 1'b0; bus.dcache_wdata = 16'h0000;

        // Reset in the middle of a D fill, then a fresh request.
        bus.dcache_req = 1'b1; bus.dcache_addr = 16'h0A0A;
        exp_idle("rst_df_req", 1'b0);
        tick();
        rst = 1'b1;
        exp_df("rst_df_grant", 16'h0A0A);
        tick();
        rst = 1'b0; bus.dcache_req = 1'b0;
        exp_idle("rst_df_cleared", 1'b0);
        tick();
        bus.icache_req = 1'b1; bus.icache_addr = 16'h0042;
        exp_idle("rst_fresh_req", 1'b0);
        tick();
        bus.icache_req = 1'b0; bus.icache_done = 1'b1;
        exp_i("rst_fresh_grant", 16'h0042, 1'b0);
        tick();
        bus.icache_done = 1'b0;
        exp_idle("rst_fresh_idle", 1'b0);
        tick();

        // Done pulse on the last allowed cycle is a normal completion.
        bus.icache_req = 1'b1; bus.icache_addr = 16'h0333;
        exp_idle("wdl_req", 1'b0);
        tick();
        bus.icache_req = 1'b0;
        for (int i = 0; i < 62; i++) begin
            exp_i("wdl_hold", 16'h0333, 1'b0);
            tick();
        end
        bus.icache_done = 1'b1;
        exp_i("wdl_done_at_limit", 16'h0333, 1'b0);
        tick();
        bus.icache_done = 1'b0;
        exp_idle("wdl_no_error", 1'b0);
        tick();

        // Watchdog timeout: 63 granted cycles, then IDLE with sticky error.
        bus.icache_req = 1'b1; bus.icache_addr = 16'h0777;
        exp_idle("wd_req", 1'b0);
        tick();
        bus.icache_req = 1'b0;
        for (int i = 0; i < 63; i++) begin
            exp_i("wd_hold", 16'h0777, 1'b0);
            tick();
        end
        exp_idle("wd_timeout", 1'b1);
        tick();
        exp_idle("wd_error_sticky", 1'b1);
        tick();
        bus.icache_req = 1'b1; bus.icache_addr = 16'h0555;
        exp_idle("wd_err_req", 1'b1);
        tick();
        bus.icache_req = 1'b0; bus.icache_done = 1'b1;
        exp_i("wd_err_grant", 16'h0555, 1'b1);
        tick();
        bus.icache_done = 1'b0; rst = 1'b1;
        exp_idle("wd_err_before_rst", 1'b1);
        tick();
        rst = 1'b0;
        exp_idle("wd_err_cleared", 1'b0);
        tick();

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cache_mem_arbiter.md
CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk in 1, rst in 1, listed first.
REQ-002 The block SHALL have these ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- icache_req  in  1  I-cache fill request (fill FSM busy)
- icache_addr  in  16  I-cache fill address (base+offset)
- icache_done  in  1  I-cache fill finished pulse
- dcache_req  in  1  D-cache request
- dcache_wr  in  1  D-cache request is a write-through store (1) or fill (0)
- dcache_addr  in  16  D-cache address
- dcache_wdata  in  16  D-cache store data
- dcache_done  in  1  D-cache fill finished pulse
- icache_grant  out  1  memory owned by I-cache
- dcache_grant  out  1  memory owned by D-cache
- mem_enable  out  1  memory access enable
- mem_wr  out  1  memory write strobe
- mem_addr  out  16  memory address
- mem_wdata  out  16  memory write data
- arb_busy  out  1  any grant active
- arb_error  out  1  sticky grant-timeout flag

Function
REQ-003 The FSM SHALL have the states IDLE, GNT_I, GNT_DF (D fill) and GNT_DW (D write), with the state held in registers.
REQ-004 In IDLE, requests SHALL be sampled at the clock edge, and the grant SHALL be visible the following cycle (one-cycle arbitration latency).
REQ-005 The IDLE transitions SHALL be:
- dcache_req & dcache_wr -> GNT_DW
- dcache_req & ~dcache_wr -> GNT_DF
- icache_req -> GNT_I
- otherwise stay in IDLE
REQ-006 When both requests are present in IDLE, the D-cache SHALL win (fixed priority), unless REQ-018 applies.
REQ-007 GNT_I and GNT_DF SHALL be held until the owner's done pulse, then move to IDLE; this gives a mandatory one-cycle IDLE bubble between grants.
REQ-008 GNT_DW SHALL last exactly one cycle, then move to IDLE unconditionally; dcache_done SHALL be ignored in GNT_DW.
REQ-009 A done pulse from a requester that does not hold the grant SHALL be ignored.
REQ-010 A request deasserted mid-grant SHALL be ignored, and the grant SHALL be held until done or timeout.
REQ-011 The grant outputs SHALL be:
- icache_grant = (state == GNT_I)
- dcache_grant = (state == GNT_DF | state == GNT_DW)
- arb_busy = (state != IDLE)
REQ-012 mem_enable SHALL be 1 in every non-IDLE state, and mem_wr SHALL be 1 only in GNT_DW.
REQ-013 mem_addr and mem_wdata SHALL follow the owner combinationally:
- mem_addr = icache_addr in GNT_I, dcache_addr in GNT_DF/GNT_DW, 0 in IDLE
- mem_wdata = dcache_wdata in GNT_DW, else 0
REQ-014 A 6-bit watchdog SHALL clear on entry to any grant state and increment each cycle in GNT_I/GNT_DF.
REQ-015 If the watchdog reaches 63 without a done pulse, the FSM SHALL go to IDLE and set arb_error, which holds until reset.
REQ-016 A done pulse and the watchdog reaching 63 in the same cycle SHALL count as a normal completion, with no error.

Reset
REQ-017 While rst=1 at a clock edge, the following SHALL apply:
- state = IDLE
- watchdog = 0
- arb_error = 0
- round-robin pointer = D-cache-last
- all outputs = 0 the next cycle, including a reset that arrives mid-grant

Configuration
REQ-018 Macro ARB_ROUND_ROBIN_EN SHALL select the tie-break policy:
- Defined: a 1-bit last-owner register (updated on every grant entry) gives a tie in IDLE to the requester that did not own last; non-tie behaviour is unchanged.
- Undefined: fixed D-over-I priority per REQ-006, and the register is absent.

Verification
REQ-019 The bench SHALL cover these scenarios:
- icache_req=1, icache_addr=0x0040 in IDLE -> next cycle icache_grant=1, mem_enable=1, mem_addr=0x0040; icache_done pulse -> IDLE next cycle, all outputs 0.
- icache_req and dcache_req (dcache_wr=0) asserted together -> dcache_grant=1; after dcache_done, one IDLE cycle, then icache_grant=1. Under ARB_ROUND_ROBIN_EN, a second simultaneous tie after that goes to I-cache first.
- dcache_req=1, dcache_wr=1, addr=0x1234, wdata=0xBEEF -> exactly one cycle of mem_wr=1, mem_addr=0x1234, mem_wdata=0xBEEF, then IDLE.
- GNT_I held with no icache_done -> after 63 cycles the FSM returns to IDLE, arb_error=1 and stays 1; rst=1 clears it.
- rst=1 asserted during GNT_DF -> the next cycle shows all outputs 0, and a fresh request is then granted normally.
- dcache_done pulsed during GNT_I -> ignored, icache_grant stays 1.
